vau_busy_timer: RTL and testbench
=================================

# vau_busy_timer

Wishbone-mapped run controller and cycle timer inside the user project, between the management SoC and the 32x32 vector accelerator core. Firmware writes a start command; the block pulses the accelerator start, drives a busy flag onto user GPIO 20 for exactly the run duration, and counts those cycles. It records completion, timeout and overflow status for firmware readback. The GPIO flag lets the chip-level bench measure accelerator latency externally.

## Interface
Parameters:
- CNT_W, 32: cycle counter width (16..32)
- BASE_ADDR, 32'h3000_0100: register window base; window is 16 bytes

Ports:
- wb_clk_i  in  1  single clock, rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  access acknowledge
- wbs_dat_o  out  32  read data
- acc_start_o  out  1  one-cycle start pulse to accelerator
- acc_done_i  in  1  accelerator completion pulse (≥1 cycle; first cycle counts)
- busy_flag_o  out  1  to io_out[20]
- busy_flag_oeb_o  out  1  to io_oeb[20]; constant 0 (always drive)

## Operation
- Registers (offset from BASE_ADDR):
  - 0x0 CTRL (W): bit0 START, bit1 CLR (both self-clearing, only when wbs_sel_i[0]); reads 0
  - 0x4 STATUS (R/W1C): bit0 busy (RO), bit1 done, bit2 timeout, bit3 overflow (sticky, write-1-clear with sel[0])
  - 0x8 CYCLES (RO): counter, zero-extended to 32 bits
  - 0xC TIMEOUT (R/W, byte-enabled): limit; 0 disables
- Addresses outside window: no ack, wbs_dat_o = 0.
- FSM: IDLE, RUN.
  - IDLE: START write → RUN; counter cleared to 0, done/timeout/overflow cleared, acc_start_o pulsed.
  - RUN: counter increments every cycle (saturates at all-ones, sets overflow). acc_done_i=1 → IDLE, set done. Counter reaches TIMEOUT (≠0) → IDLE, set timeout.
  - acc_done_i and timeout in same cycle: done wins, timeout not set.
- START while RUN: ignored, no pulse. acc_done_i in IDLE: ignored.
- CLR: zeroes counter in IDLE only; ignored in RUN. START+CLR together: START behaviour.
- busy_flag_o = (state == RUN), registered.

## Timing
- Reset values: wbs_ack_o 0, wbs_dat_o 0, acc_start_o 0, busy_flag_o 0, busy_flag_oeb_o 0; state IDLE; counter 0, TIMEOUT 0, sticky bits 0.
- Wishbone: request sampled when cyc&stb&!ack at edge N; ack high for edge N+1 cycle only; read data valid with ack; write effects take place at edge N+1.
- START written at edge N: acc_start_o and busy_flag_o high from edge N+1; acc_start_o low after one cycle.
- Counter invariant: CYCLES equals number of rising edges at which busy_flag_o was 1 (matches external counter on GPIO 20).
- acc_done_i sampled high at edge M: busy_flag_o low from edge M; CYCLES final at edge M; done readable via a read request sampled at M+1 or later.
- Timeout: busy_flag_o drops at the edge where counter becomes TIMEOUT; CYCLES == TIMEOUT.
- Reset asserted mid-run: all outputs and state return to reset values immediately, no done set.
- CYCLES read during RUN returns value at request edge.

## Test plan
- Reset, read all four registers → 0,0,0,0; busy_flag_o 0, oeb 0.
- Write START, model acc_done_i 100 cycles after acc_start_o → busy flag high 100 edges, CYCLES=100, STATUS=0x2, one start pulse.
- TIMEOUT=50, START, no done → flag drops, CYCLES=50, STATUS=0x4; write STATUS 0x4 → STATUS=0.
- CNT_W=16, TIMEOUT=0, run 70000 cycles then done → CYCLES=0xFFFF, STATUS=0xA.
- START again during RUN and acc_done_i while IDLE → no extra pulse, counter unaffected; done/timeout same cycle with TIMEOUT=20 → STATUS=0x2.
- Assert wb_rst_i at cycle 30 of a run → flag, ack, start low immediately; subsequent CYCLES read 0; access at BASE_ADDR+0x10 gets no ack.

Source files
------------

// File: rtl/vau_busy_timer.sv
// vau_busy_timer
//   Wishbone-mapped run controller and cycle timer for the vector accelerator.
//   Firmware writes START; the block pulses acc_start_o and holds busy_flag_o
//   high for exactly the run. It counts the cycles of the run and records
//   done / timeout / overflow status.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, async active-high reset
//   wbs_*                   Wishbone classic slave, 16-byte window at BASE_ADDR
//                           0x0 CTRL (W)  0x4 STATUS (R/W1C)
//                           0x8 CYCLES (RO)  0xC TIMEOUT (R/W)
//   acc_start_o             one-cycle start pulse to the accelerator
//   acc_done_i              accelerator completion (first high cycle counts)
//   busy_flag_o             high while running; goes to io_out[20]
//   busy_flag_oeb_o         output enable for io_oeb[20], always driving (0)
module vau_busy_timer #(
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        acc_start_o,
    input  logic        acc_done_i,
    output logic        busy_flag_o,
    output logic        busy_flag_oeb_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             done_q, tmo_q, ovf_q;
    logic             done_nx, tmo_nx, ovf_nx;
    logic [31:0]      timeout_q, timeout_nx;
    logic             acc_start_nx;

    // Request captured at the sampling edge; its write effect is applied on
    // the following edge, i.e. while wbs_ack_o is high.
    logic        req_we;
    logic [1:0]  req_reg;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;

    logic        hit, req;
    logic        wr, start_cmd, clr_cmd;
    logic [2:0]  w1c;
    logic [31:0] rd_data;
    logic        unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    assign hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & hit;

    assign wr        = wbs_ack_o & req_we;
    assign start_cmd = wr & (req_reg == 2'd0) & req_sel[0] & req_dat[0];
    assign clr_cmd   = wr & (req_reg == 2'd0) & req_sel[0] & req_dat[1];
    assign w1c       = (wr && req_reg == 2'd1 && req_sel[0]) ? req_dat[3:1] : 3'b000;

    assign busy_flag_o     = (state == RUN);
    assign busy_flag_oeb_o = 1'b0;

    // Read mux reflects register contents at the request edge.
    always_comb begin
        rd_data = 32'h0;
        case (wbs_adr_i[3:2])
            2'd1:    rd_data = {28'h0, ovf_q, tmo_q, done_q, busy_flag_o};
            2'd2:    rd_data = 32'(cnt);
            2'd3:    rd_data = timeout_q;
            default: rd_data = 32'h0;
        endcase
    end

    // Next-state / datapath
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        acc_start_nx = 1'b0;
        // Clears first so that a hardware set in the same cycle wins.
        done_nx      = done_q & ~w1c[0];
        tmo_nx       = tmo_q  & ~w1c[1];
        ovf_nx       = ovf_q  & ~w1c[2];
        timeout_nx   = timeout_q;
        cnt_inc      = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

        if (wr && req_reg == 2'd3) begin
            for (int b = 0; b < 4; b++)
                if (req_sel[b]) timeout_nx[8*b +: 8] = req_dat[8*b +: 8];
        end

        case (state)
            IDLE: begin
                if (start_cmd) begin
                    state_nx     = RUN;
                    cnt_nx       = '0;
                    done_nx      = 1'b0;
                    tmo_nx       = 1'b0;
                    ovf_nx       = 1'b0;
                    acc_start_nx = 1'b1;
                end else if (clr_cmd) begin
                    cnt_nx = '0;
                end
            end
            RUN: begin
                // Every edge with the flag high is counted, including the
                // edge that ends the run.
                cnt_nx = cnt_inc;
                if (cnt == CNT_MAX) ovf_nx = 1'b1;
                if (acc_done_i) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else if (timeout_q != 32'h0 && 32'(cnt_inc) == timeout_q) begin
                    state_nx = IDLE;
                    tmo_nx   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            ovf_q       <= 1'b0;
            timeout_q   <= 32'h0;
            acc_start_o <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            done_q      <= done_nx;
            tmo_q       <= tmo_nx;
            ovf_q       <= ovf_nx;
            timeout_q   <= timeout_nx;
            acc_start_o <= acc_start_nx;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            req_we    <= 1'b0;
            req_reg   <= 2'd0;
            req_sel   <= 4'h0;
            req_dat   <= 32'h0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rd_data : 32'h0;
            if (req) begin
                req_we  <= wbs_we_i;
                req_reg <= wbs_adr_i[3:2];
                req_sel <= wbs_sel_i;
                req_dat <= wbs_dat_i;
            end
        end
    end

endmodule

// File: tb/tb_vau_busy_timer.sv
module tb_vau_busy_timer;

    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam logic [31:0] CTRL = BASE + 32'h0;
    localparam logic [31:0] STAT = BASE + 32'h4;
    localparam logic [31:0] CYC  = BASE + 32'h8;
    localparam logic [31:0] TMO  = BASE + 32'hC;

    logic        clk, rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        acc_start, acc_done, busy, oeb;

    int vectors = 0;
    int errs    = 0;
    int busy_edges = 0;
    int starts     = 0;

    vau_busy_timer #(.CNT_W(16), .BASE_ADDR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .acc_start_o(acc_start), .acc_done_i(acc_done),
        .busy_flag_o(busy), .busy_flag_oeb_o(oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each negedge with the flag high lies between two rising edges that saw it high.
    always @(negedge clk) begin
        busy_edges <= busy_edges + int'(busy);
        starts     <= starts + int'(acc_start);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Returns just after the edge that registered ack (stb dropped there).
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic got, output logic [31:0] q);
        got = 1'b0;
        q   = 32'h0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                q   = rdat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        logic g;
        logic [31:0] q;
        wb_xfer(1'b1, a, d, s, g, q);
        check({tag, "_ack"}, {31'h0, g}, 32'h1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic g;
        logic [31:0] q;
        wb_xfer(1'b0, a, 32'h0, 4'hF, g, q);
        check({tag, "_ack"}, {31'h0, g}, 32'h1);
        check(tag, q, exp);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, {31'h0, busy}, 32'h0);
    endtask

    int b0, s0;
    logic g;
    logic [31:0] q;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; wdat = 32'h0; acc_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_start", {31'h0, acc_start}, 32'h0);
        @(negedge clk) rst = 1'b0;

        // Reset state
        rd_chk("rst_ctrl", CTRL, 32'h0);
        rd_chk("rst_stat", STAT, 32'h0);
        rd_chk("rst_cyc",  CYC,  32'h0);
        rd_chk("rst_tmo",  TMO,  32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_oeb",  {31'h0, oeb},  32'h0);

        // START with sel[0] clear has no effect
        wr("nosel", CTRL, 32'h1, 4'b0010);
        @(posedge clk); #1;
        check("nosel_busy", {31'h0, busy}, 32'h0);

        // TIMEOUT byte enables
        wr("tmo_be", TMO, 32'h1234_5678, 4'b0101);
        rd_chk("tmo_be_rd", TMO, 32'h0034_0078);
        wr("tmo_zero", TMO, 32'h0, 4'hF);

        // Normal run: done sampled at the 100th edge after the start edge
        b0 = busy_edges; s0 = starts;
        wr("start1", CTRL, 32'h1, 4'h1);
        @(posedge clk); #1;
        check("start1_pulse", {31'h0, acc_start}, 32'h1);
        check("start1_busy",  {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        check("start1_pulse_end", {31'h0, acc_start}, 32'h0);
        repeat (98) @(posedge clk);
        #1 acc_done = 1'b1;
        @(posedge clk); #1 acc_done = 1'b0;
        check("run1_busy_low", {31'h0, busy}, 32'h0);
        rd_chk("run1_cyc",  CYC,  32'd100);
        rd_chk("run1_stat", STAT, 32'h2);
        check("run1_flag_edges", busy_edges - b0, 100);
        check("run1_starts", starts - s0, 1);

        // Timeout run
        wr("tmo50", TMO, 32'd50, 4'hF);
        b0 = busy_edges;
        wr("start2", CTRL, 32'h1, 4'h1);
        @(posedge clk); #1;
        wait_idle("run2_idle", 200);
        rd_chk("run2_cyc",  CYC,  32'd50);
        rd_chk("run2_stat", STAT, 32'h4);
        check("run2_flag_edges", busy_edges - b0, 50);
        wr("w1c", STAT, 32'h4, 4'h1);
        rd_chk("w1c_stat", STAT, 32'h0);

        // Saturation: 16-bit counter, no timeout
        wr("tmo0", TMO, 32'h0, 4'hF);
        wr("start3", CTRL, 32'h1, 4'h1);
        rd_chk("run3_stat_busy", STAT, 32'h1);
        repeat (70000) @(posedge clk);
        #1 acc_done = 1'b1;
        @(posedge clk); #1 acc_done = 1'b0;
        rd_chk("run3_cyc",  CYC,  32'h0000_FFFF);
        rd_chk("run3_stat", STAT, 32'hA);

        // START during RUN is ignored; done in IDLE is ignored
        b0 = busy_edges; s0 = starts;
        wr("start4", CTRL, 32'h1, 4'h1);
        @(posedge clk); #1;
        wr("start4_again", CTRL, 32'h3, 4'h1);
        repeat (10) @(posedge clk);
        #1 acc_done = 1'b1;
        @(posedge clk); #1 acc_done = 1'b0;
        check("run4_starts", starts - s0, 1);
        wb_xfer(1'b0, CYC, 32'h0, 4'hF, g, q);
        check("run4_cyc_vs_flag", q, 32'(busy_edges - b0));
        repeat (2) @(posedge clk);
        #1 acc_done = 1'b1;
        repeat (3) @(posedge clk);
        #1 acc_done = 1'b0;
        check("idle_done_busy", {31'h0, busy}, 32'h0);
        rd_chk("idle_done_stat", STAT, 32'h2);
        check("idle_done_starts", starts - s0, 1);

        // Done and timeout on the same edge: done wins
        wr("tmo20", TMO, 32'd20, 4'hF);
        wr("start5", CTRL, 32'h1, 4'h1);
        @(posedge clk); #1;
        repeat (19) @(posedge clk);
        #1 acc_done = 1'b1;
        @(posedge clk); #1 acc_done = 1'b0;
        check("run5_busy_low", {31'h0, busy}, 32'h0);
        rd_chk("run5_cyc",  CYC,  32'd20);
        rd_chk("run5_stat", STAT, 32'h2);

        // CLR in IDLE
        wr("clr", CTRL, 32'h2, 4'h1);
        rd_chk("clr_cyc", CYC, 32'h0);

        // Reset during a run
        wr("tmo0b", TMO, 32'h0, 4'hF);
        wr("start6", CTRL, 32'h1, 4'h1);
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mrst_busy",  {31'h0, busy}, 32'h0);
        check("mrst_ack",   {31'h0, ack}, 32'h0);
        check("mrst_start", {31'h0, acc_start}, 32'h0);
        @(negedge clk) rst = 1'b0;
        rd_chk("mrst_cyc",  CYC,  32'h0);
        rd_chk("mrst_stat", STAT, 32'h0);
        rd_chk("mrst_tmo",  TMO,  32'h0);

        // Outside the window: no ack
        wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, g, q);
        check("oow_ack", {31'h0, g}, 32'h0);
        check("oow_dat", rdat, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
